timer_dev: RTL and testbench

- Memory-mapped countdown timer on the CPU data port.
- Downstream of the pipeline's M-stage memory interface: consumes m_data_addr / m_data_wdata / m_data_byteen and returns read data that the M-stage data-extend path folds into M_DM_RD.
- Raises a level/pulse interrupt request for the upcoming exception/CP0 stage.
- Three registers: CTRL, PRESET, COUNT.

---
 rtl/timer_defs_pkg.sv | 38 +++
 rtl/timer_dev_bus_if.sv | 53 +++++
 rtl/timer_dev.sv | 111 +++++++++++
 tb/tb_timer_dev.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_defs_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, MODE codes, FSM state encodings and a byte-lane merge helper.
package timer_defs;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CTRL_W = 4;

    // Word offsets taken from addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Replace only the byte lanes whose enable is set
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_val,
                                                     input logic [WIDTH-1:0] new_val,
                                                     input logic [3:0]       be);
        logic [WIDTH-1:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_dev_bus_if.sv
// Bus side of the timer: block decode, per-register write strobes,
// byte-lane merge of write data and the zero-latency read mux.
module timer_bus_if
    import timer_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        byteen_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [WIDTH-1:0]  preset_i,
    input  logic [WIDTH-1:0]  count_i,
    output logic              sel_c_o,
    output logic              ctrl_we_c_o,
    output logic              preset_we_c_o,
    output logic [CTRL_W-1:0] ctrl_wdata_c_o,
    output logic [WIDTH-1:0]  preset_wdata_c_o,
    output logic [31:0]       rdata_c_o
);

    logic [1:0]       off_c;
    logic             we_c;
    logic [WIDTH-1:0] ctrl_merged_c;
    logic             unused_c;

    assign sel_c_o = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off_c   = addr_i[3:2];
    assign we_c    = sel_c_o && (byteen_i != 4'h0);

    assign ctrl_we_c_o   = we_c && (off_c == OFF_CTRL);
    assign preset_we_c_o = we_c && (off_c == OFF_PRESET);

    // CTRL upper bits do not exist, so writes to them simply fall away
    assign ctrl_merged_c    = merge_bytes(WIDTH'(ctrl_i), wdata_i, byteen_i);
    assign ctrl_wdata_c_o   = ctrl_merged_c[CTRL_W-1:0];
    assign preset_wdata_c_o = merge_bytes(preset_i, wdata_i, byteen_i);

    assign unused_c = ^{addr_i[1:0], ctrl_merged_c[WIDTH-1:CTRL_W]};

    always_comb begin
        rdata_c_o = 32'h0;
        if (sel_c_o) begin
            case (off_c)
                OFF_CTRL:   rdata_c_o = 32'(ctrl_i);
                OFF_PRESET: rdata_c_o = preset_i;
                OFF_COUNT:  rdata_c_o = count_i;
                default:    rdata_c_o = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// load/count/interrupt FSM and an interrupt request gated by CTRL.IM.
module timer_dev
    import timer_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq
);

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              irq_flag_q, irq_flag_d;

    logic              ctrl_we_c;
    logic              preset_we_c;
    logic [CTRL_W-1:0] ctrl_wdata_c;
    logic [WIDTH-1:0]  preset_wdata_c;
    logic [1:0]        mode_c;

    timer_bus_if #(
        .BASE_ADDR (BASE_ADDR)
    ) u_bus_if (
        .addr_i           (addr),
        .wdata_i          (wdata),
        .byteen_i         (byteen),
        .ctrl_i           (ctrl_q),
        .preset_i         (preset_q),
        .count_i          (count_q),
        .sel_c_o          (sel),
        .ctrl_we_c_o      (ctrl_we_c),
        .preset_we_c_o    (preset_we_c),
        .ctrl_wdata_c_o   (ctrl_wdata_c),
        .preset_wdata_c_o (preset_wdata_c),
        .rdata_c_o        (rdata)
    );

    assign mode_c = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign irq    = irq_flag_q & ctrl_q[CTRL_IM];

    // Reserved modes 2/3 fall through to one-shot behaviour
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (ctrl_we_c || preset_we_c) irq_flag_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d    = ST_INT;
                    irq_flag_d = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            ST_INT: begin
                if (mode_c == MODE_RELOAD) begin
                    state_d    = ST_LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes take priority over the FSM's automatic EN clear
        if (ctrl_we_c)   ctrl_d   = ctrl_wdata_c;
        if (preset_we_c) preset_d = preset_wdata_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a table of register-access vectors followed by
// hand-written sequences for counting, reload, abort, masking and reset corners.
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .sel    (sel),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_sel;
        logic        exp_irq;
        string       name;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus write; the write lands on the posedge this task waits for
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'h0;
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
        addr = BASE + 32'(off);
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        chk(name, 32'(irq), 32'(exp));
    endtask

    initial begin
        vecs[0]  = '{1'b0, BASE + 32'h0,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "rst_ctrl"};
        vecs[1]  = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "rst_preset"};
        vecs[2]  = '{1'b0, BASE + 32'h8,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "rst_count"};
        vecs[3]  = '{1'b0, BASE + 32'hC,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "rst_offc"};
        vecs[4]  = '{1'b0, BASE + 32'h10, 32'h0,         4'h0,    32'h0,         1'b0, 1'b0, "unsel_above"};
        vecs[5]  = '{1'b1, BASE + 32'h4,  32'h1122_3344, 4'hF,    32'h0,         1'b1, 1'b0, "wr_preset"};
        vecs[6]  = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h1122_3344, 1'b1, 1'b0, "rd_preset_full"};
        vecs[7]  = '{1'b1, BASE + 32'h4,  32'hAABB_CCDD, 4'b0100, 32'h0,         1'b1, 1'b0, "wr_preset_lane2"};
        vecs[8]  = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h11BB_3344, 1'b1, 1'b0, "rd_preset_lane2"};
        vecs[9]  = '{1'b1, BASE + 32'h8,  32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 1'b0, "wr_count"};
        vecs[10] = '{1'b0, BASE + 32'h8,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "count_ro"};
        vecs[11] = '{1'b1, BASE + 32'h14, 32'h0,         4'hF,    32'h0,         1'b0, 1'b0, "wr_unsel"};
        vecs[12] = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h11BB_3344, 1'b1, 1'b0, "unsel_no_wr"};
        vecs[13] = '{1'b1, BASE + 32'h0,  32'hFFFF_FFF6, 4'hF,    32'h0,         1'b1, 1'b0, "wr_ctrl_hi"};
        vecs[14] = '{1'b0, BASE + 32'h0,  32'h0,         4'h0,    32'h0000_0006, 1'b1, 1'b0, "ctrl_mask"};
        vecs[15] = '{1'b1, BASE + 32'h4,  32'h1234_5678, 4'h0,    32'h0,         1'b1, 1'b0, "wr_be0"};
        vecs[16] = '{1'b0, BASE + 32'h4,  32'h0,         4'h0,    32'h11BB_3344, 1'b1, 1'b0, "be0_no_wr"};
        vecs[17] = '{1'b1, BASE + 32'h0,  32'h0000_0F00, 4'b0010, 32'h0,         1'b1, 1'b0, "wr_ctrl_b1"};
        vecs[18] = '{1'b0, BASE + 32'h0,  32'h0,         4'h0,    32'h0000_0006, 1'b1, 1'b0, "ctrl_b1_kept"};
        vecs[19] = '{1'b1, BASE + 32'h0,  32'h0,         4'b0001, 32'h0,         1'b1, 1'b0, "wr_ctrl_zero"};
        vecs[20] = '{1'b0, BASE + 32'h0,  32'h0,         4'h0,    32'h0,         1'b1, 1'b0, "ctrl_zero"};
        vecs[21] = '{1'b0, 32'h0000_7E00, 32'h0,         4'h0,    32'h0,         1'b0, 1'b0, "unsel_below"};

        reset  = 1'b1;
        addr   = BASE;
        wdata  = 32'h0;
        byteen = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].a, vecs[i].wd, vecs[i].be);
            end else begin
                @(negedge clk);
                addr = vecs[i].a;
                #1;
                chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
                chk({vecs[i].name, "_sel"}, 32'(sel), 32'(vecs[i].exp_sel));
                chk({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
            end
        end

        // One-shot, PRESET=3: COUNT 3..0 after E0+2..E0+5, irq after E0+6
        do_write(BASE + 32'h4, 32'd3, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(2); rd(4'h8, 32'd3, "m0_cnt3");
        step(1); rd(4'h8, 32'd2, "m0_cnt2");
        step(1); rd(4'h8, 32'd1, "m0_cnt1");
        step(1); rd(4'h8, 32'd0, "m0_cnt0"); chk_irq(1'b0, "m0_irq_e5");
        step(1); chk_irq(1'b1, "m0_irq_e6");
        step(1); rd(4'h0, 32'h8, "m0_en_cleared"); chk_irq(1'b1, "m0_irq_e7");
        step(3); chk_irq(1'b1, "m0_irq_held");
        do_write(BASE + 32'h0, 32'h0, 4'hF);
        chk_irq(1'b0, "m0_irq_clear");

        // Auto-reload, PRESET=2: one-cycle pulses after E0+5 and E0+10
        do_write(BASE + 32'h4, 32'd2, 4'hF);
        do_write(BASE + 32'h0, 32'hB, 4'hF);
        step(4); chk_irq(1'b0, "m1_irq_e4");
        step(1); chk_irq(1'b1, "m1_irq_e5");
        step(1); chk_irq(1'b0, "m1_irq_e6");
        step(1); rd(4'h8, 32'd2, "m1_reload");
        step(2); chk_irq(1'b0, "m1_irq_e9");
        step(1); chk_irq(1'b1, "m1_irq_e10");
        do_write(BASE + 32'h0, 32'h0, 4'hF);
        chk_irq(1'b0, "m1_irq_e11");
        step(3);

        // Abort: EN cleared on E0+5 freezes COUNT at 7
        do_write(BASE + 32'h4, 32'd10, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(4);
        do_write(BASE + 32'h0, 32'h8, 4'hF);
        step(3); rd(4'h8, 32'd7, "abort_cnt"); chk_irq(1'b0, "abort_irq");
        step(5); rd(4'h8, 32'd7, "abort_frozen"); rd(4'h0, 32'h8, "abort_ctrl");

        // Masked completion: irq stays low, EN still auto-clears
        do_write(BASE + 32'h4, 32'd2, 4'hF);
        do_write(BASE + 32'h0, 32'h1, 4'hF);
        step(5); rd(4'h8, 32'd0, "mask_cnt0"); chk_irq(1'b0, "mask_irq_e5");
        step(1); chk_irq(1'b0, "mask_irq_e6");
        step(1); rd(4'h0, 32'h0, "mask_en_cleared");

        // PRESET=0: irq after E0+3
        do_write(BASE + 32'h4, 32'd0, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(2); chk_irq(1'b0, "p0_irq_e2");
        step(1); chk_irq(1'b1, "p0_irq_e3");
        do_write(BASE + 32'h0, 32'h0, 4'hF);
        chk_irq(1'b0, "p0_irq_clear");

        // PRESET write on the flag-setting edge does not lose the interrupt
        do_write(BASE + 32'h4, 32'd1, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(3);
        do_write(BASE + 32'h4, 32'd5, 4'hF);
        chk_irq(1'b1, "race_flag_set");
        step(1); chk_irq(1'b1, "race_flag_held"); rd(4'h0, 32'h8, "race_en_cleared");
        do_write(BASE + 32'h0, 32'h0, 4'hF);
        chk_irq(1'b0, "race_clear");

        // CTRL write on INT's EN-clear edge: written EN wins, count restarts
        do_write(BASE + 32'h4, 32'd0, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(3); chk_irq(1'b1, "enwin_irq_e3");
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        rd(4'h0, 32'h9, "enwin_ctrl"); chk_irq(1'b0, "enwin_irq_e4");
        step(3); chk_irq(1'b1, "enwin_irq_e7");
        do_write(BASE + 32'h0, 32'h0, 4'hF);
        step(2);

        // PRESET write mid-count leaves COUNT alone; reset then clears everything
        do_write(BASE + 32'h4, 32'd10, 4'hF);
        do_write(BASE + 32'h0, 32'h9, 4'hF);
        step(2);
        do_write(BASE + 32'h4, 32'd20, 4'hF);
        step(4); rd(4'h8, 32'd5, "midcnt_preset_wr");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd(4'h0, 32'h0, "rst_mid_ctrl");
        rd(4'h4, 32'h0, "rst_mid_preset");
        rd(4'h8, 32'h0, "rst_mid_count");
        chk_irq(1'b0, "rst_mid_irq");
        step(4); rd(4'h8, 32'h0, "rst_mid_idle"); chk_irq(1'b0, "rst_mid_irq_late");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
